stream_sync_fifo: RTL and testbench
===================================

# stream_sync_fifo

Single-clock FIFO with valid/ready handshakes on both sides, arbitrary (non-power-of-two) depth, an optional registered output stage, occupancy count, programmable almost-full/almost-empty flags and synchronous flush. It is the general-purpose successor to the basic shift-in/shift-out FIFO. It sits between streaming pipeline stages, where back-pressure must be honoured rather than flagged as overflow/underflow.

## Interface
- DATA_WIDTH, 32, payload width in bits (>=1)
- DEPTH, 64, total entry capacity, any integer >=2; includes the output register when OUT_REG=1
- OUT_REG, 0, 0: m_data read directly from storage; 1: m_data driven from a dedicated output register
- AF_THRESH, DEPTH-4, almost_full asserted when count >= AF_THRESH
- AE_THRESH, 4, almost_empty asserted when count <= AE_THRESH
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- flush  in  1  synchronous clear of all contents
- s_data  in  DATA_WIDTH  write payload
- s_valid  in  1  write request
- s_ready  out  1  FIFO can accept; registered
- m_data  out  DATA_WIDTH  head-of-queue payload
- m_valid  out  1  m_data holds a valid entry
- m_ready  in  1  consumer accepts m_data
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- almost_full  out  1  count >= AF_THRESH; registered
- almost_empty  out  1  count <= AE_THRESH; registered

## Operation
- Push = s_valid && s_ready. Pop = m_valid && m_ready. Both are evaluated at the same edge.
- Count update: push only +1; pop only -1; push and pop together leave it unchanged. Count never exceeds DEPTH and never underflows.
- Pointers wrap from DEPTH-1 to 0 explicitly. No power-of-two assumption; full/empty are decided from count, never from pointer equality.
- s_ready is a register loaded with (next_count < DEPTH). It does not depend on m_ready, so there is no combinational ready path and no write-through when full.
- s_valid && !s_ready is legal back-pressure. The data is ignored and state is unchanged.
- OUT_REG=0: m_data = storage[rd_ptr]; m_valid = (count != 0).
- OUT_REG=1: the output register holds the head entry.
  - It loads from storage when it is empty or being popped and storage is non-empty.
  - It loads directly from s_data when storage is empty and a push occurs.
  - m_valid is the register's valid bit. Storage plus register never hold more than DEPTH entries.
- Data order is strict FIFO. No bypass from s_data to m_data within the same cycle in either mode.
- Flush: pointers, count and m_valid clear at the next edge, and push/pop in that cycle are discarded. s_ready and the flags take their empty values at that same edge.
- Priority: reset > flush > push/pop.

## Timing
- Reset values: s_ready=0, m_valid=0, count=0, almost_full=0, almost_empty=1. m_data is don't-care.
- After rst_n deasserts, s_ready=1 from the first edge onward.
- Write-to-read latency from empty:
  - OUT_REG=0: an entry pushed at edge N has m_valid=1 in the cycle after edge N.
  - OUT_REG=1: same single-cycle latency, because the output register loads from s_data.
- Full-rate streaming: with m_ready=1 held, one push and one pop per cycle are sustained indefinitely and count stays constant.
- Full: s_ready falls in the cycle after the push that makes count=DEPTH. A pop at that full state re-asserts s_ready the cycle after the pop.
- Flags, count and s_ready all reflect the state after the most recent edge.
- Reset or flush mid-burst: no entry pushed before the clearing edge is ever presented afterwards.

## Test plan
- Fill/drain, DEPTH=5 OUT_REG=0:
  - Push 1..5 with m_ready=0: count=5, s_ready=0 at cycle 6, almost_full set at count>=1 (AF_THRESH=1).
  - Sixth s_valid is ignored.
  - Then m_ready=1 pops 1,2,3,4,5 in order; count returns to 0 and m_valid=0.
- Wrap-around, DEPTH=5: push 12 entries (0xA0..0xAB) with random m_ready → output order is exactly 0xA0..0xAB with no drops and no duplicates; rd_ptr and wr_ptr each pass the 4→0 wrap.
- Simultaneous push/pop at full, DEPTH=4 OUT_REG=1: fill to 4, then hold s_valid=1 with m_ready=1.
  - Cycle 1: a pop occurs, s_ready still 0.
  - Next cycle: s_ready=1 and one push lands.
  - count oscillates 4→3→4 and never exceeds 4.
- Steady stream, OUT_REG=1: push 100 incrementing words with m_ready=1 throughout → first m_valid one cycle after first push; 100 pops in 100 consecutive cycles; count ≤1.
- Flush mid-burst: push 0x11,0x22,0x33, then assert flush together with s_valid (0x44) and m_ready → next cycle count=0, m_valid=0, almost_empty=1; subsequent push of 0x55 emerges first.
- Reset mid-operation: push 3 entries, pull rst_n low one cycle → s_ready=0 and count=0 during reset; s_ready=1 one edge after release; no stale entry appears on m_data with m_valid=1.

Source files
------------

// File: rtl/stream_sync_fifo_if.sv
// Valid/ready stream bundle: the producing side uses master, the consuming side uses slave.
interface stream_sync_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/stream_sync_fifo.sv
// Single-clock valid/ready FIFO with arbitrary depth, optional output register,
// occupancy count, registered almost-full/almost-empty flags and synchronous flush.
module stream_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int OUT_REG    = 0,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  stream_sync_fifo_if.slave          s,
  stream_sync_fifo_if.master         m,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       almost_empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  s_ready_q;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  m_valid_int;
  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  rd_en;
  logic                  direct_load;
  logic                  out_valid_next;
  logic [CW-1:0]         store_cnt;
  logic [CW-1:0]         next_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign m_valid_int = (OUT_REG != 0) ? out_valid : (count != '0);
  assign push        = s.valid && s_ready_q;
  assign pop         = m_valid_int && m.ready;
  assign s.ready     = s_ready_q;
  assign m.valid     = m_valid_int;
  assign m.data      = (OUT_REG != 0) ? out_data : mem[rd_ptr];

  // With the output register, count covers storage plus the register; the register
  // refills from storage first and only takes s_data directly when storage is empty.
  always_comb begin
    wr_en          = push;
    rd_en          = pop;
    direct_load    = 1'b0;
    out_valid_next = out_valid;
    store_cnt      = count;
    if (OUT_REG != 0) begin
      store_cnt = count - CW'(out_valid);
      if (!out_valid || pop) begin
        rd_en          = (store_cnt != '0);
        direct_load    = !rd_en && push;
        out_valid_next = rd_en || direct_load;
      end else begin
        rd_en = 1'b0;
      end
      wr_en = push && !direct_load;
    end
    next_count = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      s_ready_q    <= 1'b0;
      out_valid    <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      s_ready_q    <= 1'b1;
      out_valid    <= 1'b0;
      almost_full  <= (AF_THRESH <= 0);
      almost_empty <= (AE_THRESH >= 0);
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      count        <= next_count;
      s_ready_q    <= (next_count < CW'(DEPTH));
      out_valid    <= out_valid_next;
      almost_full  <= (int'(next_count) >= AF_THRESH);
      almost_empty <= (int'(next_count) <= AE_THRESH);
    end
  end

  // Payload storage carries no reset; stale words are never presented because
  // pointers, count and the output valid bit are all cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s.data;
    if (OUT_REG != 0) begin
      if (rd_en)            out_data <= mem[rd_ptr];
      else if (direct_load) out_data <= s.data;
    end
  end
endmodule

// File: tb/tb_stream_sync_fifo.sv
// Drives a DEPTH=5 direct-output FIFO and a DEPTH=4 registered-output FIFO with shared
// stimulus and checks both against a queue-style reference model every cycle.
module tb_stream_sync_fifo;
  localparam int DW = 8;
  localparam int HN = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          s_valid;
  logic          m_ready;
  logic [DW-1:0] s_data;

  always #5 clk = ~clk;

  stream_sync_fifo_if #(.DATA_WIDTH(DW)) s0 ();
  stream_sync_fifo_if #(.DATA_WIDTH(DW)) m0 ();
  stream_sync_fifo_if #(.DATA_WIDTH(DW)) s1 ();
  stream_sync_fifo_if #(.DATA_WIDTH(DW)) m1 ();

  assign s0.valid = s_valid;
  assign s0.data  = s_data;
  assign m0.ready = m_ready;
  assign s1.valid = s_valid;
  assign s1.data  = s_data;
  assign m1.ready = m_ready;

  logic [2:0] count0, count1;
  logic       af0, ae0, af1, ae1;

  stream_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(5), .OUT_REG(0), .AF_THRESH(1), .AE_THRESH(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s(s0), .m(m0),
    .count(count0), .almost_full(af0), .almost_empty(ae0));

  stream_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .OUT_REG(1), .AF_THRESH(3), .AE_THRESH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s(s1), .m(m1),
    .count(count1), .almost_full(af1), .almost_empty(ae1));

  logic          got_rdy [2];
  logic          got_mv  [2];
  logic          got_af  [2];
  logic          got_ae  [2];
  logic [2:0]    got_cnt [2];
  logic [DW-1:0] got_data[2];

  assign got_rdy[0]  = s0.ready;
  assign got_rdy[1]  = s1.ready;
  assign got_mv[0]   = m0.valid;
  assign got_mv[1]   = m1.valid;
  assign got_data[0] = m0.data;
  assign got_data[1] = m1.data;
  assign got_af[0]   = af0;
  assign got_af[1]   = af1;
  assign got_ae[0]   = ae0;
  assign got_ae[1]   = ae1;
  assign got_cnt[0]  = count0;
  assign got_cnt[1]  = count1;

  int mdep[2] = '{5, 4};
  int maf [2] = '{1, 3};
  int mae [2] = '{1, 1};

  // Reference: every accepted word is logged in order; occupancy is simply the
  // number logged minus the number consumed, and the head is the oldest unconsumed word.
  logic [DW-1:0] hist [2][HN];
  int            wcnt [2];
  int            rcnt [2];
  bit            exp_rdy [2];
  bit            exp_af  [2];
  bit            exp_ae  [2];

  always @(posedge clk) begin : model
    int sz;
    bit pu, po;
    for (int d = 0; d < 2; d++) begin
      sz = wcnt[d] - rcnt[d];
      pu = s_valid && exp_rdy[d];
      po = (sz != 0) && m_ready;
      if (!rst_n) begin
        rcnt[d]    = wcnt[d];
        exp_rdy[d] = 1'b0;
        exp_af[d]  = 1'b0;
        exp_ae[d]  = 1'b1;
      end else begin
        if (flush) begin
          rcnt[d] = wcnt[d];
        end else begin
          if (po) rcnt[d]++;
          if (pu) begin
            hist[d][wcnt[d] % HN] = s_data;
            wcnt[d]++;
          end
        end
        sz = wcnt[d] - rcnt[d];
        exp_rdy[d] = (sz < mdep[d]);
        exp_af[d]  = (sz >= maf[d]);
        exp_ae[d]  = (sz <= mae[d]);
      end
    end
  end

  bit chk_en = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d at %0t: got 0x%0h, expected 0x%0h", name, d, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    int sz;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        sz = wcnt[d] - rcnt[d];
        checkOutput("s_ready", d, 32'(got_rdy[d]), 32'(exp_rdy[d]));
        checkOutput("count", d, 32'(got_cnt[d]), sz);
        checkOutput("m_valid", d, 32'(got_mv[d]), 32'(sz != 0));
        checkOutput("almost_full", d, 32'(got_af[d]), 32'(exp_af[d]));
        checkOutput("almost_empty", d, 32'(got_ae[d]), 32'(exp_ae[d]));
        if (sz != 0) checkOutput("m_data", d, 32'(got_data[d]), 32'(hist[d][rcnt[d] % HN]));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [DW-1:0] dat, input logic mr, input logic fl);
    s_valid = v;
    s_data  = dat;
    m_ready = mr;
    flush   = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk_en = 1'b1;
    step();
    checkOutput("rst_count", 0, 32'(count0), 0);
    checkOutput("rst_s_ready", 0, 32'(s0.ready), 0);
    checkOutput("rst_almost_empty", 1, 32'(ae1), 1);
    checkOutput("rst_m_valid", 1, 32'(m1.valid), 0);

    rst_n = 1'b1;
    step();
    checkOutput("ready_after_rst", 0, 32'(s0.ready), 1);
    checkOutput("ready_after_rst", 1, 32'(s1.ready), 1);

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      step();
    end
    checkOutput("fill_count", 0, 32'(count0), 5);
    checkOutput("fill_s_ready", 0, 32'(s0.ready), 0);
    checkOutput("fill_almost_full", 0, 32'(af0), 1);
    checkOutput("fill_count", 1, 32'(count1), 4);
    checkOutput("fill_s_ready", 1, 32'(s1.ready), 0);

    applyStimulus(1'b1, 8'h06, 1'b0, 1'b0);
    step();
    checkOutput("ignored_push_count", 0, 32'(count0), 5);

    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      checkOutput("drain_order", 0, 32'(m0.data), i);
      step();
    end
    checkOutput("drained_count", 0, 32'(count0), 0);
    checkOutput("drained_m_valid", 0, 32'(m0.valid), 0);
    checkOutput("drained_count", 1, 32'(count1), 0);

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 8'h40, 1'b1, 1'b0);
    step();
    checkOutput("full_pop_count", 1, 32'(count1), 3);
    checkOutput("full_pop_s_ready", 1, 32'(s1.ready), 1);
    checkOutput("full_pop_head", 1, 32'(m1.data), 32'h32);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'h41 + i), 1'b1, 1'b0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (8) step();

    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 8'(8'h11 * i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 8'h44, 1'b1, 1'b1);
    step();
    checkOutput("flush_count", 0, 32'(count0), 0);
    checkOutput("flush_m_valid", 0, 32'(m0.valid), 0);
    checkOutput("flush_almost_empty", 0, 32'(ae0), 1);
    checkOutput("flush_m_valid", 1, 32'(m1.valid), 0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("post_flush_head", 0, 32'(m0.data), 32'h55);
    checkOutput("post_flush_head", 1, 32'(m1.data), 32'h55);
    checkOutput("post_flush_m_valid", 1, 32'(m1.valid), 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    step();

    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      step();
    end
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h64, 1'b1, 1'b0);
    step();
    checkOutput("midrst_s_ready", 0, 32'(s0.ready), 0);
    checkOutput("midrst_count", 0, 32'(count0), 0);
    checkOutput("midrst_m_valid", 1, 32'(m1.valid), 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    checkOutput("release_s_ready", 0, 32'(s0.ready), 1);
    checkOutput("release_s_ready", 1, 32'(s1.ready), 1);
    checkOutput("release_m_valid", 0, 32'(m0.valid), 0);

    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
      step();
      if (i == 0) begin
        checkOutput("stream_first_valid", 1, 32'(m1.valid), 1);
        checkOutput("stream_first_data", 1, 32'(m1.data), 0);
      end
    end
    checkOutput("stream_count", 1, 32'(count1), 1);
    checkOutput("stream_count", 0, 32'(count0), 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    step();

    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom),
                    (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 63) == 0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (8) step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
